mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mips_mem_pkg.sv | 39 +++
 rtl/byte_lane_unit.sv | 70 +++++++
 rtl/mem_access_unit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the data-memory access path: request sizes, FSM states and lane selects.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } mau_state_t;

  localparam logic [1:0] LANE_B0 = 2'd0;
  localparam logic [1:0] LANE_B1 = 2'd1;
  localparam logic [1:0] LANE_B2 = 2'd2;
  localparam logic [1:0] LANE_B3 = 2'd3;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  // True when the size code is illegal or the low address bits break natural alignment.
  function automatic logic is_bad_shape(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_HALF:    bad = addr_lo[0];
      SIZE_WORD:    bad = (addr_lo != 2'b00);
      SIZE_ILLEGAL: bad = 1'b1;
      default:      bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Little-endian lane logic: extracts and extends load data, and merges store data into a word.
import mips_mem_pkg::*;

module byte_lane_unit (
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rd_word,
  input  logic [31:0] base_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte  = rd_word[7:0];
    sel_half  = rd_word[15:0];
    load_data = '0;

    case (byte_off)
      LANE_B0: sel_byte = rd_word[7:0];
      LANE_B1: sel_byte = rd_word[15:8];
      LANE_B2: sel_byte = rd_word[23:16];
      LANE_B3: sel_byte = rd_word[31:24];
      default: sel_byte = rd_word[7:0];
    endcase

    case (byte_off[1])
      HALF_LO: sel_half = rd_word[15:0];
      HALF_HI: sel_half = rd_word[31:16];
      default: sel_half = rd_word[15:0];
    endcase

    case (size)
      SIZE_BYTE: load_data = {{24{is_signed & sel_byte[7]}}, sel_byte};
      SIZE_HALF: load_data = {{16{is_signed & sel_half[15]}}, sel_half};
      SIZE_WORD: load_data = rd_word;
      default:   load_data = '0;
    endcase
  end

  // Sub-word stores keep the untouched lanes of the word read back from memory.
  always_comb begin
    merged_word = base_word;
    case (size)
      SIZE_BYTE: begin
        case (byte_off)
          LANE_B0: merged_word[7:0]   = wdata[7:0];
          LANE_B1: merged_word[15:8]  = wdata[7:0];
          LANE_B2: merged_word[23:16] = wdata[7:0];
          LANE_B3: merged_word[31:24] = wdata[7:0];
          default: merged_word        = base_word;
        endcase
      end
      SIZE_HALF: begin
        case (byte_off[1])
          HALF_LO: merged_word[15:0]  = wdata[15:0];
          HALF_HI: merged_word[31:16] = wdata[15:0];
          default: merged_word        = base_word;
        endcase
      end
      SIZE_WORD: merged_word = wdata;
      default:   merged_word = base_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit in front of a word-addressed data memory; sub-word stores use read-modify-write.
import mips_mem_pkg::*;

module mem_access_unit #(
  parameter int ADDR_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  localparam logic [31:0] ADDR_LIMIT = 32'(ADDR_WORDS);

  mau_state_t state, state_n;

  logic        we_q;
  logic        signed_q;
  logic        err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] hold_q;
  logic [31:0] rdata_q;

  logic        accept;
  logic        req_err;
  logic [31:0] word_idx;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  assign accept   = req_valid & req_ready;
  assign req_err  = is_bad_shape(req_size, req_addr[1:0]) |
                    ({2'b00, req_addr[31:2]} >= ADDR_LIMIT);
  assign word_idx = {2'b00, addr_q[31:2]};

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  byte_lane_unit u_lanes (
    .size        (size_q),
    .is_signed   (signed_q),
    .byte_off    (addr_q[1:0]),
    .rd_word     (mem_rd),
    .base_word   (hold_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and all memory/handshake outputs; write and response are gated by reset.
  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_addr   = '0;
    mem_wd     = '0;
    mem_we     = 1'b0;

    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err) begin
            state_n = RESP;
          end else if (!req_we) begin
            state_n = READ;
          end else if (req_size == SIZE_WORD) begin
            state_n = WRITE;
          end else begin
            state_n = READ;
          end
        end
      end
      READ: begin
        mem_addr = word_idx;
        state_n  = we_q ? WRITE : RESP;
      end
      WRITE: begin
        mem_addr = word_idx;
        mem_wd   = merged_word;
        mem_we   = ~rst;
        state_n  = RESP;
      end
      RESP: begin
        resp_valid = ~rst;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Request capture, memory read holding register and response data.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      hold_q   <= '0;
      rdata_q  <= '0;
    end else begin
      if (accept) begin
        we_q     <= req_we;
        signed_q <= req_signed;
        err_q    <= req_err;
        size_q   <= req_size;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        rdata_q  <= '0;
      end
      if (state == READ) begin
        hold_q <= mem_rd;
        if (!we_q) begin
          rdata_q <= load_data;
        end
      end
    end
  end

endmodule
